// File: rtl/pacman_pkg.sv
// ---------------------------------------------------------------------------
// pacman_pkg
//   Shared definitions for the cookie bookkeeping block and its maze layout
//   ROM: scan FSM state encoding, cookie coordinate width, screen limit and
//   the default point values for normal and power cookies.
//
//   Contents:
//     scan_state_t   - FSM states of the collision scanner (IDLE / SCAN)
//     COOKIE_POS_W   - width of one cookie / pac-man coordinate
//     BOUND_W        - width used for hit-box bounds (one guard bit)
//     SCREEN_MAX     - largest legal coordinate on either axis
//     PTS_DOT_DEF    - default points for a normal cookie
//     PTS_POWER_DEF  - default points for a power cookie
// ---------------------------------------------------------------------------
package pacman_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    localparam int COOKIE_POS_W  = 10;
    localparam int BOUND_W       = COOKIE_POS_W + 1;
    localparam int SCREEN_MAX    = (1 << COOKIE_POS_W) - 1;

    localparam int PTS_DOT_DEF   = 10;
    localparam int PTS_POWER_DEF = 50;

endpackage : pacman_pkg

// File: rtl/cookie_map_rom.sv
// ---------------------------------------------------------------------------
// cookie_map_rom
//   Purely combinational maze layout: returns the screen position and power
//   flag of the cookie selected by `index`.
//
//   Layout:
//     cookie 0  : (   0, 500) normal  - hugs the left screen edge
//     cookie 1  : (1020, 500) normal  - hugs the right screen edge
//     cookie 5  : ( 100, 100) normal  - lone cookie in the top-left corner
//     others    : 8 x 8 grid, x = 200 + 90*(i mod 8),
//                 y = 200 + 90*((i div 8) mod 8); every 16th cookie
//                 (i mod 16 == 15) is a power cookie.
//   Mazes larger than 64 cookies reuse the grid positions cyclically.
//
//   Ports:
//     index  in   cookie index (0 .. N_COOKIES-1)
//     x, y   out  cookie centre, COOKIE_POS_W bits each
//     power  out  1 = power cookie
// ---------------------------------------------------------------------------
module cookie_map_rom
    import pacman_pkg::*;
#(
    parameter int N_COOKIES = 64,
    parameter int IDX_W     = $clog2(N_COOKIES)
) (
    input  logic [IDX_W-1:0]        index,
    output logic [COOKIE_POS_W-1:0] x,
    output logic [COOKIE_POS_W-1:0] y,
    output logic                    power
);

    always_comb begin
        int i;
        int col;
        int row;
        i     = int'(index);
        col   = i % 8;
        row   = (i / 8) % 8;
        x     = COOKIE_POS_W'(200 + col * 90);
        y     = COOKIE_POS_W'(200 + row * 90);
        power = ((i % 16) == 15);

        case (i)
            0: begin
                x     = COOKIE_POS_W'(0);
                y     = COOKIE_POS_W'(500);
                power = 1'b0;
            end
            1: begin
                x     = COOKIE_POS_W'(1020);
                y     = COOKIE_POS_W'(500);
                power = 1'b0;
            end
            5: begin
                x     = COOKIE_POS_W'(100);
                y     = COOKIE_POS_W'(100);
                power = 1'b0;
            end
            default: ;
        endcase
    end

endmodule : cookie_map_rom

// File: rtl/cookie_bank.sv
// ---------------------------------------------------------------------------
// cookie_bank
//   Tracks which maze cookies pac-man has eaten. Each frame_start launches a
//   scan that tests one cookie per clock against a box around the latched
//   pac-man position; alive cookies inside the box are consumed, scored and
//   announced with one-cycle strobes.
//
//   Ports:
//     Clk            in   clock, all state on rising edge
//     Reset          in   asynchronous, active-high reset
//     frame_start    in   pulse: start a scan (ignored while busy)
//     level_restart  in   pulse: re-arm all cookies, abort scan, keep score
//     Xp, Yp         in   pac-man centre
//     Sizep          in   pac-man size (hit box half-width = Sizep >> 1)
//     query_idx      in   draw-side cookie index
//     query_alive    out  combinational alive bit for query_idx (0 if out of range)
//     score          out  saturating point total
//     remaining      out  number of uneaten cookies
//     eat_pulse      out  one-cycle strobe per cookie eaten
//     power_pulse    out  one-cycle strobe when the eaten cookie is a power cookie
//     busy           out  high for the N_COOKIES cycles of a scan
//     level_clear    out  one-cycle strobe, aligned with the last cookie's eat_pulse
// ---------------------------------------------------------------------------
module cookie_bank
    import pacman_pkg::*;
#(
    parameter int N_COOKIES = 64,
    parameter int SCORE_W   = 16,
    parameter int PTS_DOT   = PTS_DOT_DEF,
    parameter int PTS_POWER = PTS_POWER_DEF
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            frame_start,
    input  logic                            level_restart,
    input  logic [COOKIE_POS_W-1:0]         Xp,
    input  logic [COOKIE_POS_W-1:0]         Yp,
    input  logic [COOKIE_POS_W-1:0]         Sizep,
    input  logic [$clog2(N_COOKIES)-1:0]    query_idx,
    output logic                            query_alive,
    output logic [SCORE_W-1:0]              score,
    output logic [$clog2(N_COOKIES+1)-1:0]  remaining,
    output logic                            eat_pulse,
    output logic                            power_pulse,
    output logic                            busy,
    output logic                            level_clear
);

    localparam int IDX_W = $clog2(N_COOKIES);
    localparam int REM_W = $clog2(N_COOKIES + 1);
    localparam int PAD_N = 1 << IDX_W;

    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(N_COOKIES - 1);
    localparam logic [REM_W-1:0]   FULL_CNT    = REM_W'(N_COOKIES);
    localparam logic [SCORE_W-1:0] PTS_DOT_V   = SCORE_W'(PTS_DOT);
    localparam logic [SCORE_W-1:0] PTS_POWER_V = SCORE_W'(PTS_POWER);
    localparam logic [BOUND_W-1:0] BOUND_MAX   = BOUND_W'(SCREEN_MAX);

    // Lower edge of the hit box, clamped at 0 instead of wrapping.
    function automatic logic [BOUND_W-1:0] bound_lo(
        input logic [COOKIE_POS_W-1:0] c,
        input logic [COOKIE_POS_W-1:0] h
    );
        if (c >= h)
            return {1'b0, c} - {1'b0, h};
        else
            return '0;
    endfunction

    // Upper edge of the hit box, clamped to the last screen coordinate.
    function automatic logic [BOUND_W-1:0] bound_hi(
        input logic [COOKIE_POS_W-1:0] c,
        input logic [COOKIE_POS_W-1:0] h
    );
        logic [BOUND_W-1:0] s;
        s = {1'b0, c} + {1'b0, h};
        if (s > BOUND_MAX)
            return BOUND_MAX;
        else
            return s;
    endfunction

    // Score addition that sticks at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(
        input logic [SCORE_W-1:0] a,
        input logic [SCORE_W-1:0] b
    );
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[SCORE_W])
            return '1;
        else
            return s[SCORE_W-1:0];
    endfunction

    scan_state_t               state;
    logic [IDX_W-1:0]          scan_idx;
    logic [N_COOKIES-1:0]      alive;

    // Pac-man geometry captured at scan start; data only, so no reset.
    logic [COOKIE_POS_W-1:0]   lat_x;
    logic [COOKIE_POS_W-1:0]   lat_y;
    logic [COOKIE_POS_W-1:0]   lat_half;

    logic [COOKIE_POS_W-1:0]   cookie_x;
    logic [COOKIE_POS_W-1:0]   cookie_y;
    logic                      cookie_power;

    logic [BOUND_W-1:0]        x_lo;
    logic [BOUND_W-1:0]        x_hi;
    logic [BOUND_W-1:0]        y_lo;
    logic [BOUND_W-1:0]        y_hi;
    logic                      hit;
    logic                      cur_alive;
    logic                      start_scan;

    // Zero-padded to a power of two so any index value selects a defined bit;
    // indices at or beyond N_COOKIES read back as eaten.
    logic [PAD_N-1:0]          alive_pad;

    cookie_map_rom #(
        .N_COOKIES (N_COOKIES),
        .IDX_W     (IDX_W)
    ) u_map (
        .index (scan_idx),
        .x     (cookie_x),
        .y     (cookie_y),
        .power (cookie_power)
    );

    assign alive_pad   = PAD_N'(alive);
    assign query_alive = alive_pad[query_idx];
    assign cur_alive   = alive_pad[scan_idx];
    assign busy        = (state == ST_SCAN);

    assign x_lo = bound_lo(lat_x, lat_half);
    assign x_hi = bound_hi(lat_x, lat_half);
    assign y_lo = bound_lo(lat_y, lat_half);
    assign y_hi = bound_hi(lat_y, lat_half);

    assign hit = ({1'b0, cookie_x} >= x_lo) && ({1'b0, cookie_x} <= x_hi) &&
                 ({1'b0, cookie_y} >= y_lo) && ({1'b0, cookie_y} <= y_hi);

    // level_restart wins over a coincident frame_start.
    assign start_scan = (state == ST_IDLE) && frame_start && !level_restart;

    always_ff @(posedge Clk) begin
        if (start_scan) begin
            lat_x    <= Xp;
            lat_y    <= Yp;
            lat_half <= Sizep >> 1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= ST_IDLE;
            scan_idx    <= '0;
            alive       <= '1;
            remaining   <= FULL_CNT;
            score       <= '0;
            eat_pulse   <= 1'b0;
            power_pulse <= 1'b0;
            level_clear <= 1'b0;
        end else begin
            eat_pulse   <= 1'b0;
            power_pulse <= 1'b0;
            level_clear <= 1'b0;

            if (level_restart) begin
                // Abort outright: no eat is committed on this edge either.
                state     <= ST_IDLE;
                scan_idx  <= '0;
                alive     <= '1;
                remaining <= FULL_CNT;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (frame_start) begin
                            state    <= ST_SCAN;
                            scan_idx <= '0;
                        end
                    end
                    ST_SCAN: begin
                        if (hit && cur_alive) begin
                            alive[scan_idx] <= 1'b0;
                            remaining       <= remaining - REM_W'(1);
                            score           <= sat_add(score,
                                                       cookie_power ? PTS_POWER_V : PTS_DOT_V);
                            eat_pulse       <= 1'b1;
                            power_pulse     <= cookie_power;
                            level_clear     <= (remaining == REM_W'(1));
                        end
                        if (scan_idx == LAST_IDX) begin
                            state    <= ST_IDLE;
                            scan_idx <= '0;
                        end else begin
                            scan_idx <= scan_idx + IDX_W'(1);
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        scan_idx <= '0;
                    end
                endcase
            end
        end
    end

endmodule : cookie_bank

// File: tb/tb_cookie_bank.sv
// ---------------------------------------------------------------------------
// tb_cookie_bank
//   Self-checking bench for cookie_bank with default parameters. A small
//   behavioural model (alive array, score and remaining integers, the maze
//   layout as a table) predicts every strobe of each scan and the final state.
// ---------------------------------------------------------------------------
module tb_cookie_bank;

    localparam int N       = 64;
    localparam int SCORE_M = 65535;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_start;
    logic       level_restart;
    logic [9:0] Xp;
    logic [9:0] Yp;
    logic [9:0] Sizep;
    logic [5:0] query_idx;
    logic       query_alive;
    logic [15:0] score;
    logic [6:0] remaining;
    logic       eat_pulse;
    logic       power_pulse;
    logic       busy;
    logic       level_clear;

    int checks = 0;
    int errors = 0;

    bit m_alive[N];
    int m_score;
    int m_rem;

    cookie_bank dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_start   (frame_start),
        .level_restart (level_restart),
        .Xp            (Xp),
        .Yp            (Yp),
        .Sizep         (Sizep),
        .query_idx     (query_idx),
        .query_alive   (query_alive),
        .score         (score),
        .remaining     (remaining),
        .eat_pulse     (eat_pulse),
        .power_pulse   (power_pulse),
        .busy          (busy),
        .level_clear   (level_clear)
    );

    always #5 Clk = ~Clk;

    function automatic void cookie_at(input int i, output int cx, output int cy, output bit pw);
        if (i == 0) begin
            cx = 0; cy = 500; pw = 0;
        end else if (i == 1) begin
            cx = 1020; cy = 500; pw = 0;
        end else if (i == 5) begin
            cx = 100; cy = 100; pw = 0;
        end else begin
            cx = 200 + (i % 8) * 90;
            cy = 200 + ((i / 8) % 8) * 90;
            pw = ((i % 16) == 15);
        end
    endfunction

    function automatic bit hits(input int cx, input int cy, input int px, input int py, input int sz);
        int half, xl, xh, yl, yh;
        half = sz / 2;
        xl = (px - half < 0) ? 0 : px - half;
        xh = (px + half > 1023) ? 1023 : px + half;
        yl = (py - half < 0) ? 0 : py - half;
        yh = (py + half > 1023) ? 1023 : py + half;
        return (cx >= xl) && (cx <= xh) && (cy >= yl) && (cy <= yh);
    endfunction

    function automatic void model_rearm();
        for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
        m_rem = N;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_restart();
        level_restart = 1'b1;
        tick();
        level_restart = 1'b0;
        model_rearm();
    endtask

    // Runs one full scan, checking busy and the strobes on every cycle and
    // the score, remaining count and alive vector afterwards. A frame_start
    // is re-asserted during scan cycle poke_at (values > N mean never).
    task automatic run_scan(input int px, input int py, input int sz, input int poke_at);
        bit exp_eat[N+1];
        bit exp_pw[N+1];
        bit exp_lc[N+1];
        int cx, cy, pts;
        bit pw;
        logic exp_busy;
        for (int k = 0; k <= N; k++) begin
            exp_eat[k] = 0; exp_pw[k] = 0; exp_lc[k] = 0;
        end
        for (int i = 0; i < N; i++) begin
            cookie_at(i, cx, cy, pw);
            if (m_alive[i] && hits(cx, cy, px, py, sz)) begin
                m_alive[i] = 0;
                m_rem--;
                pts = pw ? 50 : 10;
                m_score = (m_score + pts > SCORE_M) ? SCORE_M : m_score + pts;
                exp_eat[i+1] = 1;
                exp_pw[i+1]  = pw;
                exp_lc[i+1]  = (m_rem == 0);
            end
        end

        Xp = 10'(px); Yp = 10'(py); Sizep = 10'(sz);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        // Scramble the live inputs: the scan must use the latched copy.
        Xp = 10'($urandom_range(0, 1023));
        Yp = 10'($urandom_range(0, 1023));
        Sizep = 10'($urandom_range(0, 1023));
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL scan_start_busy got %b exp 1", busy);
        end

        for (int c = 1; c <= N; c++) begin
            if (c == poke_at) frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            exp_busy = (c < N);
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL scan_busy cycle %0d got %b exp %b", c, busy, exp_busy);
            end
            checks++;
            if ({eat_pulse, power_pulse, level_clear} !== {exp_eat[c], exp_pw[c], exp_lc[c]}) begin
                errors++;
                $display("FAIL scan_pulses cycle %0d got eat/pow/clr %b%b%b exp %b%b%b",
                         c, eat_pulse, power_pulse, level_clear, exp_eat[c], exp_pw[c], exp_lc[c]);
            end
        end

        tick();
        checks++;
        if ({busy, eat_pulse, power_pulse, level_clear} !== 4'b0000) begin
            errors++;
            $display("FAIL scan_after got busy/eat/pow/clr %b%b%b%b exp 0000",
                     busy, eat_pulse, power_pulse, level_clear);
        end
        checks++;
        if (score !== 16'(m_score)) begin
            errors++;
            $display("FAIL scan_score got %0d exp %0d", score, m_score);
        end
        checks++;
        if (remaining !== 7'(m_rem)) begin
            errors++;
            $display("FAIL scan_remaining got %0d exp %0d", remaining, m_rem);
        end
        for (int q = 0; q < N; q++) begin
            query_idx = 6'(q);
            #1;
            checks++;
            if (query_alive !== m_alive[q]) begin
                errors++;
                $display("FAIL scan_alive idx %0d got %b exp %b", q, query_alive, m_alive[q]);
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        #12;
        m_score = 0;
        model_rearm();
        checks++;
        if (score !== 16'd0) begin
            errors++;
            $display("FAIL reset_score got %0d exp 0", score);
        end
        checks++;
        if (remaining !== 7'd64) begin
            errors++;
            $display("FAIL reset_remaining got %0d exp 64", remaining);
        end
        checks++;
        if ({busy, eat_pulse, power_pulse, level_clear} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b%b%b%b exp 0000", busy, eat_pulse, power_pulse, level_clear);
        end
        for (int q = 0; q < N; q++) begin
            query_idx = 6'(q);
            #1;
            checks++;
            if (query_alive !== 1'b1) begin
                errors++;
                $display("FAIL reset_alive idx %0d got %b exp 1", q, query_alive);
            end
        end
        @(negedge Clk);
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_single_eat();
        run_scan(104, 104, 10, 1000);
        checks++;
        if (score !== 16'd10) begin
            errors++;
            $display("FAIL single_score got %0d exp 10", score);
        end
        checks++;
        if (remaining !== 7'd63) begin
            errors++;
            $display("FAIL single_remaining got %0d exp 63", remaining);
        end
        query_idx = 6'd5;
        #1;
        checks++;
        if (query_alive !== 1'b0) begin
            errors++;
            $display("FAIL single_alive5 got %b exp 0", query_alive);
        end
    endtask

    task automatic test_repeat();
        run_scan(104, 104, 10, 1000);
        checks++;
        if (score !== 16'd10) begin
            errors++;
            $display("FAIL repeat_score got %0d exp 10", score);
        end
    endtask

    task automatic test_clamp();
        run_scan(2, 500, 20, 1000);
        query_idx = 6'd0;
        #1;
        checks++;
        if (query_alive !== 1'b0) begin
            errors++;
            $display("FAIL clamp_left_eaten got %b exp 0", query_alive);
        end
        query_idx = 6'd1;
        #1;
        checks++;
        if (query_alive !== 1'b1) begin
            errors++;
            $display("FAIL clamp_no_wrap got %b exp 1", query_alive);
        end
    endtask

    task automatic test_busy_ignore();
        run_scan(290, 290, 100, 20);
        run_scan(830, 470, 60, 64);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            if (r == 3) do_restart();
            run_scan($urandom_range(0, 1023), $urandom_range(0, 1023),
                     $urandom_range(0, 600), $urandom_range(1, 90));
        end
    endtask

    task automatic test_restart_priority();
        int cx, cy;
        bit pw;
        do_restart();
        // Cookies 0..9 are consumed before the abort; all are normal.
        for (int i = 0; i < 10; i++) begin
            cookie_at(i, cx, cy, pw);
            if (hits(cx, cy, 511, 511, 1023))
                m_score = m_score + (pw ? 50 : 10);
        end
        Xp = 10'd511; Yp = 10'd511; Sizep = 10'd1023;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (10) tick();
        checks++;
        if (eat_pulse !== 1'b1) begin
            errors++;
            $display("FAIL restart_pre_eat got %b exp 1", eat_pulse);
        end
        level_restart = 1'b1;
        tick();
        level_restart = 1'b0;
        model_rearm();
        checks++;
        if ({busy, eat_pulse, power_pulse, level_clear} !== 4'b0000) begin
            errors++;
            $display("FAIL restart_abort got %b%b%b%b exp 0000", busy, eat_pulse, power_pulse, level_clear);
        end
        checks++;
        if (remaining !== 7'd64) begin
            errors++;
            $display("FAIL restart_remaining got %0d exp 64", remaining);
        end
        checks++;
        if (score !== 16'(m_score)) begin
            errors++;
            $display("FAIL restart_score got %0d exp %0d", score, m_score);
        end
        frame_start = 1'b1;
        level_restart = 1'b1;
        tick();
        frame_start = 1'b0;
        level_restart = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_priority_busy got %b exp 0", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_priority_busy2 got %b exp 0", busy);
        end
        for (int q = 0; q < N; q++) begin
            query_idx = 6'(q);
            #1;
            checks++;
            if (query_alive !== 1'b1) begin
                errors++;
                $display("FAIL restart_alive idx %0d got %b exp 1", q, query_alive);
            end
        end
    endtask

    task automatic test_last_power();
        int score_before;
        do_restart();
        run_scan(400, 400, 800, 1000);
        run_scan(620, 400, 800, 1000);
        run_scan(400, 830, 720, 1000);
        checks++;
        if (remaining !== 7'd1) begin
            errors++;
            $display("FAIL last_setup_remaining got %0d exp 1", remaining);
        end
        score_before = m_score;
        run_scan(830, 830, 20, 1000);
        checks++;
        if (score !== 16'(score_before + 50)) begin
            errors++;
            $display("FAIL last_power_score got %0d exp %0d", score, score_before + 50);
        end
        checks++;
        if (remaining !== 7'd0) begin
            errors++;
            $display("FAIL last_remaining got %0d exp 0", remaining);
        end
        do_restart();
        checks++;
        if (remaining !== 7'd64) begin
            errors++;
            $display("FAIL last_restart_remaining got %0d exp 64", remaining);
        end
        checks++;
        if (score !== 16'(score_before + 50)) begin
            errors++;
            $display("FAIL last_restart_score got %0d exp %0d", score, score_before + 50);
        end
    endtask

    task automatic test_reset_mid_scan();
        do_restart();
        Xp = 10'd511; Yp = 10'd511; Sizep = 10'd1023;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (30) tick();
        #2;
        Reset = 1'b1;
        #1;
        m_score = 0;
        model_rearm();
        checks++;
        if ({busy, eat_pulse, power_pulse, level_clear} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_flags got %b%b%b%b exp 0000", busy, eat_pulse, power_pulse, level_clear);
        end
        checks++;
        if (score !== 16'd0) begin
            errors++;
            $display("FAIL midreset_score got %0d exp 0", score);
        end
        checks++;
        if (remaining !== 7'd64) begin
            errors++;
            $display("FAIL midreset_remaining got %0d exp 64", remaining);
        end
        for (int q = 0; q < N; q++) begin
            query_idx = 6'(q);
            #1;
            checks++;
            if (query_alive !== 1'b1) begin
                errors++;
                $display("FAIL midreset_alive idx %0d got %b exp 1", q, query_alive);
            end
        end
        @(negedge Clk);
        Reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle got %b exp 0", busy);
        end
        run_scan(104, 104, 10, 1000);
    endtask

    task automatic test_saturation();
        for (int l = 0; l < 84; l++) begin
            do_restart();
            run_scan(511, 511, 1023, 1000);
        end
        checks++;
        if (score !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturation_score got %0d exp 65535", score);
        end
    endtask

    initial begin
        Reset         = 1'b1;
        frame_start   = 1'b0;
        level_restart = 1'b0;
        Xp            = '0;
        Yp            = '0;
        Sizep         = '0;
        query_idx     = '0;
        m_score       = 0;
        model_rearm();

        test_reset();
        test_single_eat();
        test_repeat();
        test_clamp();
        test_busy_ignore();
        test_random();
        test_restart_priority();
        test_last_power();
        test_reset_mid_scan();
        test_saturation();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cookie_bank
